sad_tree_acc: RTL and testbench
===============================

Name: sad_tree_acc

Overview:
- Parametrised, fully pipelined SAD reduction block and the successor of the fixed 256-element sum tree.
- Reduces N_ELEM absolute differences per beat through a registered radix-4 adder tree.
- Accumulates the beat sums over a multi-beat block delimited by first/last flags.
- Tracks the minimum block SAD and its candidate index across a search window. It sits between the absolute-difference array and the motion-vector decision logic.

Parameters:
- N_ELEM, 256, number of ELEM_W-bit elements per beat; any value >=1.
- ELEM_W, 8, element width in bits.
- IDX_W, 10, candidate index width.
- OUT_W, 24, width of the accumulated and best sums.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of pipeline valids, accumulator and best tracker
- in_valid  in  1  beat present; the block accepts a beat every cycle and has no backpressure
- in_first  in  1  first beat of a block, qualified by in_valid
- in_last  in  1  last beat of a block, qualified by in_valid
- in_srch_start  in  1  block is the first candidate of a search; sampled on the in_last beat
- in_srch_end  in  1  block is the last candidate of a search; sampled on the in_last beat
- in_idx  in  IDX_W  candidate index; sampled on the in_last beat
- in_data  in  N_ELEM*ELEM_W  element i occupies bits [(i+1)*ELEM_W-1 : i*ELEM_W]; elements are unsigned
- out_valid  out  1  one-cycle pulse when a block sum completes
- out_sum  out  OUT_W  block SAD
- out_idx  out  IDX_W  index of the completed block
- best_sum  out  OUT_W  running minimum SAD of the current search
- best_idx  out  IDX_W  index of best_sum
- srch_done  out  1  one-cycle pulse; best_* is final for the search

Behaviour:
- Tree depth
  - L = ceil(log4(N_ELEM)), with a minimum of 1.
  - The element count is padded with zeros to 4^L.
  - Level k sums groups of 4 and widens by 2 bits, so level-k width is ELEM_W+2k.
  - The tree needs no saturation.
- Pipeline
  - Stage 0 registers in_data.
  - Stages 1..L register one tree level each.
  - Stage L+1 is the accumulator.
  - in_valid, in_first, in_last, in_idx and the search flags travel in a matching shift register.
  - Data registers may be non-resettable; valid and flag registers are reset.
- Accumulator, on a valid beat at stage L+1:
  - in_first: acc = beat_sum.
  - Otherwise: acc = acc + beat_sum, saturating at 2^OUT_W-1.
  - A first-and-last beat is a single-beat block.
  - A beat without a preceding first since reset or clear accumulates onto 0.
  - in_valid=0 gaps inside a block are allowed; the accumulator holds.
- Output timing
  - out_valid pulses on the beat tagged in_last, exactly LAT = L+2 cycles after that beat is sampled (LAT=6 for N_ELEM=256).
  - out_sum and out_idx are valid with out_valid and hold until the next pulse.
- Best tracker, one cycle after out_valid:
  - srch_start block: best_sum = out_sum, best_idx = out_idx, unconditionally.
  - Otherwise: update only if out_sum < best_sum, strictly. Ties keep the earlier candidate.
  - A block with both srch_start and srch_end is a one-candidate search.
  - srch_done pulses in the same cycle that the srch_end block's comparison lands in best_*.
- Throughput: one beat per cycle sustained. Back-to-back single-beat blocks give out_valid on consecutive cycles, and the tracker keeps up.
- Reset values
  - out_valid=0, out_sum=0, out_idx=0, srch_done=0, best_idx=0.
  - best_sum = all-ones.
  - acc=0 and all valid/flag pipeline registers 0.
- clear
  - Has the same effect as reset on the next edge, for everything except data registers.
  - Beats in flight are discarded, and no out_valid or srch_done follows from them.
  - in_valid in the same cycle as clear is discarded.
- Reset mid-block: the partial block is lost. The first block after release needs in_first.

Test Plan:
- N_ELEM=256, single beat with all elements 0xFF, first=last=1, idx=5 -> out_valid at cycle 6, out_sum=65280, out_idx=5.
- 4-beat block with every element 1 and a 2-cycle in_valid gap between beats 2 and 3 -> one out_valid, out_sum=1024, LAT after beat 4.
- Search of 3 back-to-back single-beat blocks:
  - Sums 500, 300, 300 with idx 0,1,2; srch_start on block 0, srch_end on block 2.
  - Required: out_valid on 3 consecutive cycles, srch_done once, best_sum=300, best_idx=1.
- clear asserted 2 cycles after a last beat -> no out_valid, no srch_done; best_sum=all-ones, out_sum=0.
- N_ELEM=5 (L=2, LAT=4), elements 1..5 -> out_sum=15 at cycle 4; padding contributes 0.
- rst_n pulsed low mid-block, then a new block with in_first -> outputs reset immediately; the new block's sum is unaffected by pre-reset beats.

Source files
------------

// File: rtl/sad_tree_acc_if.sv
// Bus bundle for sad_tree_acc: beat input side, clear, and block/search results.
// Valid-only handshake: a beat is taken on every clock edge where in_valid=1.
// There is no ready; the consumer of out_* must accept every out_valid pulse.
//   master : drives clear and in_*, observes out_*/best_*/srch_done
//   slave  : the reduction block
interface sad_tree_acc_if #(
  parameter int N_ELEM = 256,
  parameter int ELEM_W = 8,
  parameter int IDX_W  = 10,
  parameter int OUT_W  = 24
) ();
  logic                     clear;
  logic                     in_valid;
  logic                     in_first;
  logic                     in_last;
  logic                     in_srch_start;
  logic                     in_srch_end;
  logic [IDX_W-1:0]         in_idx;
  logic [N_ELEM*ELEM_W-1:0] in_data;
  logic                     out_valid;
  logic [OUT_W-1:0]         out_sum;
  logic [IDX_W-1:0]         out_idx;
  logic [OUT_W-1:0]         best_sum;
  logic [IDX_W-1:0]         best_idx;
  logic                     srch_done;

  modport master (
    output clear, in_valid, in_first, in_last, in_srch_start, in_srch_end,
           in_idx, in_data,
    input  out_valid, out_sum, out_idx, best_sum, best_idx, srch_done
  );

  modport slave (
    input  clear, in_valid, in_first, in_last, in_srch_start, in_srch_end,
           in_idx, in_data,
    output out_valid, out_sum, out_idx, best_sum, best_idx, srch_done
  );
endinterface

// File: rtl/sad_tree_acc.sv
// Pipelined SAD reduction: registered radix-4 adder tree over N_ELEM unsigned
// elements, saturating block accumulator delimited by first/last, and a
// minimum-SAD tracker over a search window.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : sad_tree_acc_if.slave (clear, in_* beat, out_*/best_*/srch_done)
// Latency from a last beat being sampled to out_valid is L+2 cycles, with
// L = max(1, ceil(log4(N_ELEM))). best_*/srch_done land one cycle later.
module sad_tree_acc #(
  parameter int N_ELEM = 256,
  parameter int ELEM_W = 8,
  parameter int IDX_W  = 10,
  parameter int OUT_W  = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  sad_tree_acc_if.slave bus
);

  function automatic int calc_levels(input int n);
    int lv;
    int cap;
    lv  = 1;
    cap = 4;
    while (cap < n) begin
      cap = cap * 4;
      lv  = lv + 1;
    end
    return lv;
  endfunction

  localparam int L      = calc_levels(N_ELEM);
  localparam int PAD_N  = 4 ** L;
  localparam int SUM_W  = ELEM_W + 2 * L;
  localparam int WIDE_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
  localparam logic [OUT_W-1:0] SUM_MAX = '1;

  // Zero-extension pads the element count up to 4^L; the padding leaves
  // are constant zero and fall away in synthesis.
  logic [PAD_N*ELEM_W-1:0] in_pad;
  assign in_pad = (PAD_N*ELEM_W)'(bus.in_data);

  // Level k holds 4^(L-k) nodes of ELEM_W+2k bits; four inputs can grow a
  // sum by at most 2 bits, so no level can overflow.
  for (genvar k = 0; k <= L; k++) begin : g_lvl
    localparam int CNT = 4 ** (L - k);
    localparam int W   = ELEM_W + 2 * k;
    logic [W-1:0] node [CNT];
    if (k == 0) begin : g_leaf
      always_ff @(posedge clk)
        for (int i = 0; i < CNT; i++)
          node[i] <= in_pad[i*ELEM_W +: ELEM_W];
    end else begin : g_add
      always_ff @(posedge clk)
        for (int i = 0; i < CNT; i++)
          node[i] <= {2'b00, g_lvl[k-1].node[4*i]}   + {2'b00, g_lvl[k-1].node[4*i+1]}
                   + {2'b00, g_lvl[k-1].node[4*i+2]} + {2'b00, g_lvl[k-1].node[4*i+3]};
    end
  end

  logic [SUM_W-1:0] beat_sum;
  assign beat_sum = g_lvl[L].node[0];

  // Control shift register aligned with the tree: index j matches level j.
  logic [L:0]       v_q, first_q, last_q, ss_q, se_q;
  logic [IDX_W-1:0] idx_q [L+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0; first_q <= '0; last_q <= '0; ss_q <= '0; se_q <= '0;
      for (int j = 0; j <= L; j++) idx_q[j] <= '0;
    end else if (bus.clear) begin
      v_q <= '0; first_q <= '0; last_q <= '0; ss_q <= '0; se_q <= '0;
      for (int j = 0; j <= L; j++) idx_q[j] <= '0;
    end else begin
      v_q     <= {v_q[L-1:0],     bus.in_valid};
      first_q <= {first_q[L-1:0], bus.in_first};
      last_q  <= {last_q[L-1:0],  bus.in_last};
      ss_q    <= {ss_q[L-1:0],    bus.in_srch_start};
      se_q    <= {se_q[L-1:0],    bus.in_srch_end};
      idx_q[0] <= bus.in_idx;
      for (int j = 1; j <= L; j++) idx_q[j] <= idx_q[j-1];
    end
  end

  // Accumulator stage. The extra headroom bit in WIDE_W lets the saturation
  // test be a plain compare against the all-ones OUT_W value.
  logic [OUT_W-1:0]  acc_q;
  logic [WIDE_W-1:0] acc_wide;
  logic [OUT_W-1:0]  acc_next;

  always_comb begin
    acc_wide = WIDE_W'(beat_sum);
    if (!first_q[L]) acc_wide = WIDE_W'(beat_sum) + WIDE_W'(acc_q);
    acc_next = (acc_wide > WIDE_W'(SUM_MAX)) ? SUM_MAX : acc_wide[OUT_W-1:0];
  end

  logic             out_valid_q;
  logic [OUT_W-1:0] out_sum_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             trk_start_q, trk_end_q;
  logic [OUT_W-1:0] best_sum_q;
  logic [IDX_W-1:0] best_idx_q;
  logic             srch_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0; out_valid_q <= 1'b0; out_sum_q <= '0; out_idx_q <= '0;
      trk_start_q <= 1'b0; trk_end_q <= 1'b0;
      best_sum_q <= '1; best_idx_q <= '0; srch_done_q <= 1'b0;
    end else if (bus.clear) begin
      acc_q <= '0; out_valid_q <= 1'b0; out_sum_q <= '0; out_idx_q <= '0;
      trk_start_q <= 1'b0; trk_end_q <= 1'b0;
      best_sum_q <= '1; best_idx_q <= '0; srch_done_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (v_q[L]) begin
        acc_q <= acc_next;
        if (last_q[L]) begin
          out_valid_q <= 1'b1;
          out_sum_q   <= acc_next;
          out_idx_q   <= idx_q[L];
          trk_start_q <= ss_q[L];
          trk_end_q   <= se_q[L];
        end
      end
      // Tracker reads the registered result one cycle after out_valid; a
      // back-to-back pulse overwrites out_sum_q on this same edge, so the
      // compare still sees the block it belongs to.
      srch_done_q <= out_valid_q & trk_end_q;
      if (out_valid_q && (trk_start_q || out_sum_q < best_sum_q)) begin
        best_sum_q <= out_sum_q;
        best_idx_q <= out_idx_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.best_sum  = best_sum_q;
  assign bus.best_idx  = best_idx_q;
  assign bus.srch_done = srch_done_q;

endmodule

// File: tb/tb_sad_tree_acc.sv
// Directed bench for sad_tree_acc: a 256-element instance (LAT=6) and a
// 5-element instance (LAT=4) sharing clock and reset.
module tb_sad_tree_acc;

  localparam int OUT_W = 24;
  localparam int IDX_W = 10;

  logic clk;
  logic rst_n;

  sad_tree_acc_if #(.N_ELEM(256), .ELEM_W(8), .IDX_W(IDX_W), .OUT_W(OUT_W)) bus ();
  sad_tree_acc_if #(.N_ELEM(5),   .ELEM_W(8), .IDX_W(IDX_W), .OUT_W(OUT_W)) bus5 ();

  sad_tree_acc #(.N_ELEM(256), .ELEM_W(8), .IDX_W(IDX_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  sad_tree_acc #(.N_ELEM(5), .ELEM_W(8), .IDX_W(IDX_W), .OUT_W(OUT_W)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5));

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int errors = 0;
  int checks = 0;
  int ov_cnt = 0, sd_cnt = 0, ov5_cnt = 0;
  int last_ov_cyc = 0, sd_cyc = 0, ov5_cyc = 0;
  int beat_cyc = 0;
  logic [OUT_W-1:0] ov5_sum;
  logic [OUT_W-1:0] ov_sum_q[$];
  int               ov_cyc_q[$];
  logic [OUT_W-1:0] exp_q[$];

  // monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      ov_cnt++;
      last_ov_cyc = cyc;
      ov_sum_q.push_back(bus.out_sum);
      ov_cyc_q.push_back(cyc);
    end
    if (bus.srch_done === 1'b1) begin
      sd_cnt++;
      sd_cyc = cyc;
    end
    if (bus5.out_valid === 1'b1) begin
      ov5_cnt++;
      ov5_cyc = cyc;
      ov5_sum = bus5.out_sum;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_beat(input logic first, input logic last, input logic ss,
                            input logic se, input logic [IDX_W-1:0] idx,
                            input logic [2047:0] data);
    @(posedge clk); #1;
    bus.clear         = 1'b0;
    bus.in_valid      = 1'b1;
    bus.in_first      = first;
    bus.in_last       = last;
    bus.in_srch_start = ss;
    bus.in_srch_end   = se;
    bus.in_idx        = idx;
    bus.in_data       = data;
    beat_cyc          = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
      bus.in_srch_start = 1'b0; bus.in_srch_end = 1'b0;
      bus5.in_valid = 1'b0; bus5.in_first = 1'b0; bus5.in_last = 1'b0;
    end
  endtask

  function automatic logic [2047:0] fill_data(input int s);
    logic [2047:0] d;
    int rem;
    int e;
    d   = '0;
    rem = s;
    for (int i = 0; i < 256; i++) begin
      e = (rem > 255) ? 255 : rem;
      d[i*8 +: 8] = 8'(e);
      rem = rem - e;
    end
    return d;
  endfunction

  function automatic logic [2047:0] all_elems(input logic [7:0] v);
    return {256{v}};
  endfunction

  int base_ov, base_sd;

  initial begin
    rst_n = 1'b0;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.in_srch_start = 1'b0; bus.in_srch_end = 1'b0; bus.in_idx = '0; bus.in_data = '0;
    bus5.clear = 1'b0; bus5.in_valid = 1'b0; bus5.in_first = 1'b0; bus5.in_last = 1'b0;
    bus5.in_srch_start = 1'b0; bus5.in_srch_end = 1'b0; bus5.in_idx = '0; bus5.in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // reset values
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum",   bus.out_sum,   0);
    check("rst_out_idx",   bus.out_idx,   0);
    check("rst_srch_done", bus.srch_done, 0);
    check("rst_best_sum",  bus.best_sum,  24'hFFFFFF);
    check("rst_best_idx",  bus.best_idx,  0);

    // single beat, all 0xFF, one-candidate search
    base_ov = ov_cnt; base_sd = sd_cnt; ov_sum_q.delete(); ov_cyc_q.delete();
    drive_beat(1, 1, 1, 1, 10'd5, all_elems(8'hFF));
    idle(10);
    check("t1_pulses",   ov_cnt - base_ov, 1);
    check("t1_latency",  last_ov_cyc - beat_cyc, 6);
    check("t1_out_sum",  bus.out_sum, 65280);
    check("t1_out_idx",  bus.out_idx, 5);
    check("t1_best_sum", bus.best_sum, 65280);
    check("t1_best_idx", bus.best_idx, 5);
    check("t1_done_cnt", sd_cnt - base_sd, 1);
    check("t1_done_cyc", sd_cyc - last_ov_cyc, 1);

    // 4-beat block of ones with a 2-cycle gap between beats 2 and 3
    base_ov = ov_cnt; base_sd = sd_cnt;
    drive_beat(1, 0, 0, 0, 10'd0, all_elems(8'h01));
    drive_beat(0, 0, 0, 0, 10'd0, all_elems(8'h01));
    idle(2);
    drive_beat(0, 0, 0, 0, 10'd0, all_elems(8'h01));
    drive_beat(0, 1, 0, 0, 10'd3, all_elems(8'h01));
    idle(10);
    check("t2_pulses",   ov_cnt - base_ov, 1);
    check("t2_latency",  last_ov_cyc - beat_cyc, 6);
    check("t2_out_sum",  bus.out_sum, 1024);
    check("t2_best_sum", bus.best_sum, 1024);
    check("t2_no_done",  sd_cnt - base_sd, 0);

    // three back-to-back single-beat candidates: 500, 300, 300
    base_ov = ov_cnt; base_sd = sd_cnt; ov_sum_q.delete(); ov_cyc_q.delete();
    exp_q = '{24'd500, 24'd300, 24'd300};
    drive_beat(1, 1, 1, 0, 10'd0, fill_data(500));
    drive_beat(1, 1, 0, 0, 10'd1, fill_data(300));
    drive_beat(1, 1, 0, 1, 10'd2, fill_data(300));
    idle(10);
    check("t3_pulses", ov_cnt - base_ov, 3);
    if (ov_sum_q.size() == 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("t3_sum%0d", i), ov_sum_q[i], exp_q[i]);
      check("t3_consec01", ov_cyc_q[1] - ov_cyc_q[0], 1);
      check("t3_consec12", ov_cyc_q[2] - ov_cyc_q[1], 1);
    end
    check("t3_done_cnt", sd_cnt - base_sd, 1);
    check("t3_best_sum", bus.best_sum, 300);
    check("t3_best_idx", bus.best_idx, 1);

    // clear two cycles after a last beat, with a beat offered alongside clear
    base_ov = ov_cnt; base_sd = sd_cnt;
    drive_beat(1, 1, 1, 1, 10'd4, all_elems(8'h02));
    idle(1);
    drive_beat(1, 1, 1, 1, 10'd6, all_elems(8'hFF));
    bus.clear = 1'b1;
    idle(10);
    check("t4_no_pulse",  ov_cnt - base_ov, 0);
    check("t4_no_done",   sd_cnt - base_sd, 0);
    check("t4_best_sum",  bus.best_sum, 24'hFFFFFF);
    check("t4_best_idx",  bus.best_idx, 0);
    check("t4_out_sum",   bus.out_sum, 0);
    check("t4_out_idx",   bus.out_idx, 0);

    // reset in the middle of a block
    drive_beat(1, 1, 1, 1, 10'd7, all_elems(8'h01));
    idle(8);
    check("t6_pre_sum", bus.out_sum, 256);
    drive_beat(1, 0, 0, 0, 10'd0, all_elems(8'h02));
    drive_beat(0, 0, 0, 0, 10'd0, all_elems(8'h02));
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out_sum",  bus.out_sum, 0);
    check("t6_rst_best_sum", bus.best_sum, 24'hFFFFFF);
    check("t6_rst_best_idx", bus.best_idx, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    base_ov = ov_cnt;
    drive_beat(1, 0, 0, 0, 10'd0, all_elems(8'h01));
    drive_beat(0, 1, 0, 0, 10'd9, all_elems(8'h01));
    idle(10);
    check("t6_pulses",   ov_cnt - base_ov, 1);
    check("t6_out_sum",  bus.out_sum, 512);
    check("t6_out_idx",  bus.out_idx, 9);
    check("t6_best_sum", bus.best_sum, 512);

    // 5-element instance, elements 1..5, padding to 16 leaves
    @(posedge clk); #1;
    bus5.in_valid = 1'b1; bus5.in_first = 1'b1; bus5.in_last = 1'b1;
    bus5.in_idx   = 10'd2;
    bus5.in_data  = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    beat_cyc      = cyc;
    idle(8);
    check("t5_pulses",  ov5_cnt, 1);
    check("t5_latency", ov5_cyc - beat_cyc, 4);
    check("t5_out_sum", ov5_sum, 15);
    check("t5_out_idx", bus5.out_idx, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
